cc_miss_req_scheduler: RTL and testbench
========================================

Name: cc_miss_req_scheduler

Overview:
- Sequences cache-line refills for the cache controller.
- Accepts miss requests from the hit/miss stage and issues one AXI AR read burst per miss: critical-word-first, WRAP, 8 beats x 64 bit.
- Pushes each miss address into the miss address FIFO consumed by the data fill unit.
- Limits outstanding refills, suppresses duplicate refills of a line already in flight, and retires entries when the fill unit writes the line to SRAM.

Parameters:
- MAX_OUTSTANDING, 2, maximum refills in flight (1..4); sets outstanding table depth.
- LINE_OFS_W, 6, byte-offset width of a 64-byte line; line address is addr[31:LINE_OFS_W].

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- miss_req_valid_i  input  1  miss request valid
- miss_req_addr_i  input  32  miss byte address
- miss_req_ready_o  output  1  miss request accepted this cycle when high with valid
- mem_arvalid_o  output  1  AXI AR valid
- mem_araddr_o  output  32  AXI AR address
- mem_arlen_o  output  4  AXI AR length, constant 7
- mem_arsize_o  output  3  AXI AR size, constant 3'b011 (8 bytes)
- mem_arburst_o  output  2  AXI AR burst, constant 2'b10 (WRAP)
- mem_arready_i  input  1  AXI AR ready
- miss_addr_fifo_full_i  input  1  miss address FIFO full
- miss_addr_fifo_wren_o  output  1  miss address FIFO push
- miss_addr_fifo_wdata_o  output  32  miss address pushed
- fill_done_i  input  1  one-cycle pulse: fill unit wrote a complete line to SRAM
- outstanding_o  output  3  current number of refills in flight
- err_o  output  1  sticky protocol error flag

Behaviour:
- Reset, synchronous on rst_n low, also mid-operation:
  - arvalid=0, araddr=0, fifo_wren=0, outstanding=0, err=0.
  - All table entries invalid; pointers 0; state IDLE.
  - An in-flight AR is dropped without completing the handshake.
- States: IDLE, ADDR.
- Accept condition: state==IDLE and outstanding<MAX_OUTSTANDING and !miss_addr_fifo_full_i and no duplicate.
  - miss_req_ready_o is combinational from these terms only; it does not depend on miss_req_valid_i.
- Duplicate: miss_req_addr_i[31:LINE_OFS_W] equals the line address of any valid table entry.
  - Compared against the table before any same-cycle retire, so a request matching the line retiring this cycle stalls one extra cycle.
- Acceptance (valid & ready), same cycle:
  - miss_addr_fifo_wren_o=1 and miss_addr_fifo_wdata_o=miss_req_addr_i (combinational pass-through).
  - Next cycle: table[tail] gets the line address and valid; tail advances mod MAX_OUTSTANDING; state goes to ADDR.
  - mem_araddr_o is registered as {addr[31:3],3'b000} so the critical word is first.
- ADDR state:
  - arvalid=1; araddr, arlen, arsize and arburst are held stable until arready.
  - On arvalid & arready, arvalid drops the next cycle and state goes to IDLE.
  - Minimum spacing between two accepts is 2 cycles when arready is immediate.
- Retire: fill_done_i with outstanding>0 invalidates table[head] and advances head. Refills complete in AR issue order (single AXI ID).
- Simultaneous accept and retire: outstanding unchanged; both pointers advance.
- Error: fill_done_i with outstanding==0 sets err_o, which stays set until reset; state and counters are unaffected.
- outstanding_o is registered; it equals the number of valid entries and never exceeds MAX_OUTSTANDING.
- arlen, arsize and arburst are constant even while arvalid=0.
- Latency: request accepted at cycle T gives arvalid high at T+1.

Decomposition:
- cc_pkg holds: AXI burst constants (BURST_WRAP=2'b10, SIZE_8B=3'b011, LEN_LINE=4'd7), state enum, line-address typedef.
- One sub-module: cc_miss_track_table, a circular outstanding table.
  - Inputs: alloc, retire, line address.
  - Outputs: dup hit, count, err.

Test Plan:
- Single miss, addr 0x0001_2348, arready immediate -> fifo_wren at T with data 0x0001_2348; arvalid at T+1 with araddr 0x0001_2348, arlen 7, arburst 2'b10; outstanding 1; fill_done -> outstanding 0.
- MAX_OUTSTANDING=2, three misses to distinct lines, no fill_done -> first two accepted; third has ready=0 and outstanding=2; after fill_done the third is accepted and outstanding=2.
- Duplicate: miss 0x0000_1040 in flight, new request 0x0000_1078 (same line) -> ready=0 until the cycle after fill_done; then accepted and a second AR is issued.
- Backpressure: arready held 0 for 5 cycles -> arvalid and araddr stable for 5 cycles, ready=0 throughout; miss_addr_fifo_full_i=1 -> no accept and no fifo_wren.
- Accept and fill_done in the same cycle with outstanding=1 -> outstanding stays 1; head and tail both advance.
- fill_done with outstanding=0 -> err_o=1 and sticky; assert rst_n=0 while in ADDR -> next cycle arvalid=0, outstanding=0, err=0.

Source files
------------

// File: rtl/cc_pkg.sv
// ---------------------------------------------------------------------------
// cc_pkg
// Shared constants and types for the cache controller refill path.
//   - AXI AR burst shape for one 64-byte line: WRAP, 8 beats of 8 bytes.
//   - Miss scheduler state encodings, kept as plain constants so older
//     blocks that compare raw state bits keep working.
//   - Line-address type for the default 64-byte line geometry.
// ---------------------------------------------------------------------------
package cc_pkg;

  // AXI AR burst attributes for one cache-line refill
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [3:0] LEN_LINE   = 4'd7;

  // Miss scheduler states
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_ADDR = 1'b1;

  // Line address for the default 64-byte line (addr[31:6])
  localparam int LINE_OFS_W_DEF = 6;
  typedef logic [31-LINE_OFS_W_DEF:0] line_addr_t;

endpackage

// File: rtl/cc_miss_track_table.sv
// ---------------------------------------------------------------------------
// cc_miss_track_table
// Circular table of line addresses whose refill is in flight.
// Entries are allocated at the tail and retired from the head; refills
// finish in issue order, so head always points at the oldest refill.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   alloc      : write line into table[tail] (caller guarantees room)
//   retire     : fill unit finished a line; ignored when table is empty
//   line       : line address for both allocation and duplicate lookup
//   dup        : line matches any valid entry (before this cycle's retire)
//   count      : number of valid entries
//   err        : sticky, set by a retire while the table is empty
// ---------------------------------------------------------------------------
module cc_miss_track_table #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int LINE_W          = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc,
  input  logic              retire,
  input  logic [LINE_W-1:0] line,
  output logic              dup,
  output logic [2:0]        count,
  output logic              err
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [MAX_OUTSTANDING-1:0] valid;
  logic [LINE_W-1:0]          lines [MAX_OUTSTANDING];
  logic [PTR_W-1:0]           head;
  logic [PTR_W-1:0]           tail;
  logic                       do_retire;

  // Pointers wrap explicitly so non-power-of-two depths work too
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_retire = retire && (count != 3'd0);

  // Duplicate lookup sees the table as it stands this cycle, so a line
  // that is retiring right now still counts as in flight
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (valid[i] && (lines[i] == line)) dup = 1'b1;
    end
  end

  // head == tail with both alloc and retire only happens when the table is
  // empty (no retire) or full (no alloc), so the two valid writes never
  // collide on the same entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= 3'd0;
      err   <= 1'b0;
    end else begin
      if (alloc) begin
        lines[tail] <= line;
        valid[tail] <= 1'b1;
        tail        <= ptr_next(tail);
      end
      if (do_retire) begin
        valid[head] <= 1'b0;
        head        <= ptr_next(head);
      end
      case ({alloc, do_retire})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (retire && (count == 3'd0)) err <= 1'b1;
    end
  end

endmodule

// File: rtl/cc_miss_req_scheduler.sv
// ---------------------------------------------------------------------------
// cc_miss_req_scheduler
// Turns hit/miss-stage miss requests into AXI AR line refills
// (critical word first, WRAP, 8 x 64 bit) and pushes each miss address
// into the miss address FIFO for the data fill unit. Bounds refills in
// flight and stalls requests for a line that is already being refilled.
//
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   miss_req_valid_i/addr_i    : miss request from hit/miss stage
//   miss_req_ready_o           : request accepted when high with valid
//   mem_ar*_o, mem_arready_i   : AXI read address channel
//   miss_addr_fifo_full_i      : miss address FIFO cannot take a push
//   miss_addr_fifo_wren_o/wdata_o : FIFO push, same cycle as acceptance
//   fill_done_i                : fill unit wrote a complete line
//   outstanding_o              : refills in flight
//   err_o                      : sticky fill_done-without-refill error
// ---------------------------------------------------------------------------
module cc_miss_req_scheduler #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int LINE_OFS_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_req_valid_i,
  input  logic [31:0] miss_req_addr_i,
  output logic        miss_req_ready_o,
  output logic        mem_arvalid_o,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  input  logic        mem_arready_i,
  input  logic        miss_addr_fifo_full_i,
  output logic        miss_addr_fifo_wren_o,
  output logic [31:0] miss_addr_fifo_wdata_o,
  input  logic        fill_done_i,
  output logic [2:0]  outstanding_o,
  output logic        err_o
);

  import cc_pkg::*;

  localparam int         LINE_W  = 32 - LINE_OFS_W;
  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  state_t      state;
  logic [31:0] araddr;
  logic        dup;
  logic [2:0]  count;
  logic        err;
  logic        accept;

  cc_miss_track_table #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .LINE_W          (LINE_W)
  ) u_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .alloc  (accept),
    .retire (fill_done_i),
    .line   (miss_req_addr_i[31:LINE_OFS_W]),
    .dup    (dup),
    .count  (count),
    .err    (err)
  );

  // Ready ignores valid so the requester can look at it before committing
  assign miss_req_ready_o = (state == ST_IDLE) && (count < MAX_CNT) &&
                            !miss_addr_fifo_full_i && !dup;
  assign accept           = miss_req_valid_i && miss_req_ready_o;

  assign miss_addr_fifo_wren_o  = accept;
  assign miss_addr_fifo_wdata_o = miss_req_addr_i;

  // One AR at a time: accept loads the 8-byte-aligned critical word
  // address, ADDR holds it until the slave takes it. Reset drops any
  // pending AR without a handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      araddr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_ADDR;
            araddr <= {miss_req_addr_i[31:3], 3'b000};
          end
        end
        default: begin
          if (mem_arready_i) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_arvalid_o = (state == ST_ADDR);
  assign mem_araddr_o  = araddr;
  assign mem_arlen_o   = LEN_LINE;
  assign mem_arsize_o  = SIZE_8B;
  assign mem_arburst_o = BURST_WRAP;
  assign outstanding_o = count;
  assign err_o         = err;

endmodule

// File: tb/tb_cc_miss_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cc_miss_req_scheduler
// Self-checking bench: a queue-based model of refills in flight predicts
// every output each cycle; directed sequences pin the model with literal
// expectations, then a randomized phase runs against the model.
// ---------------------------------------------------------------------------
module tb_cc_miss_req_scheduler;

  localparam int MAX = 2;

  logic        clk;
  logic        rst_n;
  logic        miss_req_valid;
  logic [31:0] miss_req_addr;
  logic        miss_req_ready;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic [3:0]  mem_arlen;
  logic [2:0]  mem_arsize;
  logic [1:0]  mem_arburst;
  logic        mem_arready;
  logic        fifo_full;
  logic        fifo_wren;
  logic [31:0] fifo_wdata;
  logic        fill_done;
  logic [2:0]  outstanding;
  logic        err;

  int checks = 0;
  int passes = 0;

  // Model: line addresses in flight (oldest first), pending AR, sticky error
  logic [25:0] m_lines[$];
  bit          m_ar_pending;
  logic [31:0] m_ar_addr;
  bit          m_err;

  cc_miss_req_scheduler #(
    .MAX_OUTSTANDING (MAX),
    .LINE_OFS_W      (6)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .miss_req_valid_i       (miss_req_valid),
    .miss_req_addr_i        (miss_req_addr),
    .miss_req_ready_o       (miss_req_ready),
    .mem_arvalid_o          (mem_arvalid),
    .mem_araddr_o           (mem_araddr),
    .mem_arlen_o            (mem_arlen),
    .mem_arsize_o           (mem_arsize),
    .mem_arburst_o          (mem_arburst),
    .mem_arready_i          (mem_arready),
    .miss_addr_fifo_full_i  (fifo_full),
    .miss_addr_fifo_wren_o  (fifo_wren),
    .miss_addr_fifo_wdata_o (fifo_wdata),
    .fill_done_i            (fill_done),
    .outstanding_o          (outstanding),
    .err_o                  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // A request is takeable when no AR is pending, there is room, the FIFO
  // can take the address and its line is not already being refilled
  function automatic bit modelReady();
    bit d = 0;
    foreach (m_lines[i]) if (m_lines[i] == miss_req_addr[31:6]) d = 1;
    return !m_ar_pending && (m_lines.size() < MAX) && !fifo_full && !d;
  endfunction

  // Advance the model across one rising edge using the inputs held there
  task automatic modelStep();
    bit acc;
    if (!rst_n) begin
      m_lines.delete();
      m_ar_pending = 0;
      m_ar_addr    = '0;
      m_err        = 0;
    end else begin
      acc = miss_req_valid && modelReady();
      if (fill_done) begin
        if (m_lines.size() > 0) void'(m_lines.pop_front());
        else m_err = 1;
      end
      if (m_ar_pending && mem_arready) m_ar_pending = 0;
      if (acc) begin
        m_lines.push_back(miss_req_addr[31:6]);
        m_ar_pending = 1;
        m_ar_addr    = {miss_req_addr[31:3], 3'b000};
      end
    end
  endtask

  // Drive one cycle's inputs
  task automatic applyStimulus(input bit rs, input bit v, input logic [31:0] a,
                               input bit r, input bit f, input bit d);
    rst_n          = rs;
    miss_req_valid = v;
    miss_req_addr  = a;
    mem_arready    = r;
    fifo_full      = f;
    fill_done      = d;
  endtask

  // Compare every meaningful DUT output against the model
  task automatic checkOutput();
    bit exp_ready;
    exp_ready = modelReady();
    chk("ready", {31'd0, miss_req_ready}, {31'd0, exp_ready});
    chk("fifo_wren", {31'd0, fifo_wren}, {31'd0, miss_req_valid && exp_ready});
    if (miss_req_valid && exp_ready) chk("fifo_wdata", fifo_wdata, miss_req_addr);
    chk("arvalid", {31'd0, mem_arvalid}, {31'd0, m_ar_pending});
    if (m_ar_pending) chk("araddr", mem_araddr, m_ar_addr);
    chk("arlen", {28'd0, mem_arlen}, 32'd7);
    chk("arsize", {29'd0, mem_arsize}, 32'd3);
    chk("arburst", {30'd0, mem_arburst}, 32'd2);
    chk("outstanding", {29'd0, outstanding}, m_lines.size());
    chk("err", {31'd0, err}, {31'd0, m_err});
  endtask

  // One clock: edge, model update, new inputs, compare at the falling edge
  task automatic cyc(input bit rs, input bit v, input logic [31:0] a,
                     input bit r, input bit f, input bit d);
    @(posedge clk);
    modelStep();
    #1;
    applyStimulus(rs, v, a, r, f, d);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    bit          rs, v, r, f, d;
    logic [31:0] a;

    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    cyc(1, 0, 32'h0, 0, 0, 0);
    chk("rst_arvalid", {31'd0, mem_arvalid}, 32'd0);
    chk("rst_araddr", mem_araddr, 32'h0);
    chk("rst_outstanding", {29'd0, outstanding}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, miss_req_ready}, 32'd1);

    // Single miss, immediate arready, then fill
    cyc(1, 1, 32'h0001_2348, 1, 0, 0);
    chk("t1_wren", {31'd0, fifo_wren}, 32'd1);
    chk("t1_wdata", fifo_wdata, 32'h0001_2348);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("t1_arvalid", {31'd0, mem_arvalid}, 32'd1);
    chk("t1_araddr", mem_araddr, 32'h0001_2348);
    chk("t1_out1", {29'd0, outstanding}, 32'd1);
    cyc(1, 0, 32'h0, 1, 0, 1);
    chk("t1_ar_drop", {31'd0, mem_arvalid}, 32'd0);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("t1_out0", {29'd0, outstanding}, 32'd0);

    // Three distinct misses with room for two
    cyc(1, 1, 32'h0000_2000, 1, 0, 0);
    chk("t2_a_ready", {31'd0, miss_req_ready}, 32'd1);
    cyc(1, 1, 32'h0000_2040, 1, 0, 0);
    chk("t2_addr_busy", {31'd0, miss_req_ready}, 32'd0);
    cyc(1, 1, 32'h0000_2040, 1, 0, 0);
    chk("t2_b_ready", {31'd0, miss_req_ready}, 32'd1);
    cyc(1, 1, 32'h0000_2080, 1, 0, 0);
    cyc(1, 1, 32'h0000_2080, 1, 0, 0);
    chk("t2_full_ready", {31'd0, miss_req_ready}, 32'd0);
    chk("t2_out2", {29'd0, outstanding}, 32'd2);
    cyc(1, 1, 32'h0000_2080, 1, 0, 1);
    chk("t2_fill_ready", {31'd0, miss_req_ready}, 32'd0);
    cyc(1, 1, 32'h0000_2080, 1, 0, 0);
    chk("t2_c_ready", {31'd0, miss_req_ready}, 32'd1);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("t2_out_after", {29'd0, outstanding}, 32'd2);
    chk("t2_c_araddr", mem_araddr, 32'h0000_2080);
    cyc(1, 0, 32'h0, 1, 0, 1);
    cyc(1, 0, 32'h0, 1, 0, 1);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("t2_drained", {29'd0, outstanding}, 32'd0);

    // Duplicate line stalls until the cycle after its fill_done
    cyc(1, 1, 32'h0000_1040, 1, 0, 0);
    cyc(1, 1, 32'h0000_1078, 1, 0, 0);
    cyc(1, 1, 32'h0000_1078, 1, 0, 0);
    chk("t3_dup_stall", {31'd0, miss_req_ready}, 32'd0);
    cyc(1, 1, 32'h0000_1078, 1, 0, 1);
    chk("t3_dup_retiring", {31'd0, miss_req_ready}, 32'd0);
    cyc(1, 1, 32'h0000_1078, 1, 0, 0);
    chk("t3_dup_accept", {31'd0, fifo_wren}, 32'd1);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("t3_ar2", {31'd0, mem_arvalid}, 32'd1);
    chk("t3_ar2_addr", mem_araddr, 32'h0000_1078);
    cyc(1, 0, 32'h0, 1, 0, 1);
    cyc(1, 0, 32'h0, 1, 0, 0);

    // AR backpressure, then FIFO full
    cyc(1, 1, 32'h0000_3010, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 32'h0000_3100, 0, 0, 0);
      chk("t4_hold_arvalid", {31'd0, mem_arvalid}, 32'd1);
      chk("t4_hold_araddr", mem_araddr, 32'h0000_3010);
      chk("t4_hold_ready", {31'd0, miss_req_ready}, 32'd0);
    end
    cyc(1, 1, 32'h0000_3100, 1, 0, 0);
    cyc(1, 1, 32'h0000_3100, 1, 1, 0);
    chk("t4_full_ready", {31'd0, miss_req_ready}, 32'd0);
    chk("t4_full_wren", {31'd0, fifo_wren}, 32'd0);
    cyc(1, 1, 32'h0000_3100, 1, 0, 0);
    chk("t4_unfull_wren", {31'd0, fifo_wren}, 32'd1);
    cyc(1, 0, 32'h0, 1, 0, 0);
    cyc(1, 0, 32'h0, 1, 0, 1);
    cyc(1, 0, 32'h0, 1, 0, 1);
    cyc(1, 0, 32'h0, 1, 0, 0);

    // Accept and retire together with one in flight
    cyc(1, 1, 32'h0000_4000, 1, 0, 0);
    cyc(1, 0, 32'h0, 1, 0, 0);
    cyc(1, 1, 32'h0000_4040, 1, 0, 1);
    chk("t5_both_wren", {31'd0, fifo_wren}, 32'd1);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("t5_out_same", {29'd0, outstanding}, 32'd1);
    cyc(1, 0, 32'h0, 1, 0, 1);
    cyc(1, 1, 32'h0000_4040, 1, 0, 0);
    chk("t5_out0", {29'd0, outstanding}, 32'd0);
    chk("t5_reaccept", {31'd0, miss_req_ready}, 32'd1);
    cyc(1, 0, 32'h0, 1, 0, 0);
    cyc(1, 0, 32'h0, 1, 0, 1);
    cyc(1, 0, 32'h0, 1, 0, 0);

    // Spurious fill_done sets a sticky error; reset in ADDR clears all
    cyc(1, 0, 32'h0, 0, 0, 1);
    cyc(1, 0, 32'h0, 0, 0, 0);
    chk("t6_err", {31'd0, err}, 32'd1);
    chk("t6_err_out0", {29'd0, outstanding}, 32'd0);
    cyc(1, 1, 32'h0000_5000, 0, 0, 0);
    chk("t6_err_sticky", {31'd0, err}, 32'd1);
    cyc(0, 0, 32'h0, 0, 0, 0);
    chk("t6_in_addr", {31'd0, mem_arvalid}, 32'd1);
    cyc(1, 0, 32'h0, 0, 0, 0);
    chk("t6_rst_arvalid", {31'd0, mem_arvalid}, 32'd0);
    chk("t6_rst_out", {29'd0, outstanding}, 32'd0);
    chk("t6_rst_err", {31'd0, err}, 32'd0);

    // Randomized traffic over a small pool of lines to provoke duplicates
    for (int n = 0; n < 3000; n++) begin
      rs = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 99) < 60);
      a  = 32'h0000_6000 + (32'($urandom_range(0, 5)) << 6) + 32'($urandom_range(0, 63));
      r  = ($urandom_range(0, 99) < 65);
      f  = ($urandom_range(0, 99) < 15);
      d  = (m_lines.size() > 0) ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 299) == 0);
      cyc(rs, v, a, r, f, d);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
